// File: rtl/il_lane_pkg.sv
`default_nettype none
// ============================================================================
//  Package : il_lane_pkg
//  Shared types, header constants and helpers for the Interlaken receive lane.
//  Revision: 1.0  initial release
// ============================================================================
package il_lane_pkg;

  // Word-framing state of a receive lane
  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // A sync header is valid only when its two bits differ
  function automatic logic hdr_ok(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

  // Counter width able to hold max_val with one bit of headroom
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_err_window.sv
`default_nettype none
// ============================================================================
//  Module  : lane_err_window
//  Windowed error monitor: counts words and bad words inside a window and
//  flags the limit crossing and the window close. The owner decides when
//  to clear, so the same monitor serves other sync checkers.
//  Revision: 1.0  initial release
// ============================================================================
module lane_err_window
  import il_lane_pkg::*;
#(
  parameter int WIN_LEN   = 64,
  parameter int ERR_LIMIT = 16
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear_i,
  input  logic word_i,
  input  logic bad_i,
  output logic limit_hit_o,
  output logic window_end_o
);

  localparam int CW = cnt_w((WIN_LEN > ERR_LIMIT) ? WIN_LEN : ERR_LIMIT);

  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] win_inc, err_inc;

  assign win_inc = win_cnt_q + CW'(1);
  assign err_inc = err_cnt_q + CW'(1);

  // Thresholds are tested on the incremented value so the current word counts
  assign limit_hit_o  = word_i & bad_i & (err_inc == CW'(ERR_LIMIT));
  assign window_end_o = word_i & (win_inc == CW'(WIN_LEN));

  // Next-count logic: clear wins over counting
  always_comb begin
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      win_cnt_d = '0;
      err_cnt_d = '0;
    end else if (word_i) begin
      win_cnt_d = win_inc;
      if (bad_i) begin
        err_cnt_d = err_inc;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      win_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lane_word_lock.sv
`default_nettype none
// ============================================================================
//  Module  : lane_word_lock
//  67-bit word framing search and lock tracking behind gearbox_20_67.
//  Slips the gearbox until LOCK_CNT consecutive good headers are seen,
//  then emits de-inverted payload and drops lock on ERR_LIMIT bad headers
//  within a WIN_LEN-word window.
//  Revision: 1.0  initial release
// ============================================================================
module lane_word_lock
  import il_lane_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_LEN   = 64,
  parameter int ERR_LIMIT = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [66:0] din,
  input  logic        din_valid,
  output logic        slip,
  output logic        word_locked,
  output logic [63:0] dout,
  output logic        dout_ctrl,
  output logic        dout_valid,
  output logic        hdr_err
);

  localparam int GW = cnt_w(LOCK_CNT);
  localparam int WW = cnt_w(SLIP_WAIT);

  lock_state_t state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;

  logic        slip_q, slip_d;
  logic        word_locked_q, word_locked_d;
  logic [63:0] dout_q, dout_d;
  logic        dout_ctrl_q, dout_ctrl_d;
  logic        dout_valid_q, dout_valid_d;
  logic        hdr_err_q, hdr_err_d;

  logic        hdr_good;
  logic [63:0] payload;
  logic        win_word, win_clear, limit_hit, window_end;

  assign hdr_good = hdr_ok(din[65:64]);
  assign payload  = din[66] ? ~din[63:0] : din[63:0];
  assign good_inc = good_cnt_q + GW'(1);
  assign wait_inc = wait_cnt_q + WW'(1);

  lane_err_window #(
    .WIN_LEN   (WIN_LEN),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_err_window (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear_i      (win_clear),
    .word_i       (win_word),
    .bad_i        (~hdr_good),
    .limit_hit_o  (limit_hit),
    .window_end_o (window_end)
  );

  // Framing FSM next state and registered-output next values
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    slip_d       = 1'b0;
    dout_valid_d = 1'b0;
    win_word     = 1'b0;
    win_clear    = 1'b0;
    hdr_err_d    = din_valid & ~hdr_good;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (hdr_good) begin
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d      = LOCKED;
              good_cnt_d   = '0;
              win_clear    = 1'b1;
              dout_valid_d = 1'b1;
            end else begin
              good_cnt_d = good_inc;
            end
          end else begin
            good_cnt_d = '0;
            // A slip issued on the previous cycle (loss of lock) blocks a
            // back-to-back slip; the word still restarts the good count.
            if (!slip_q) begin
              slip_d     = 1'b1;
              state_d    = il_lane_pkg::SLIP_WAIT;
              wait_cnt_d = '0;
            end
          end
        end
        il_lane_pkg::SLIP_WAIT: begin
          if (wait_inc == WW'(SLIP_WAIT)) begin
            state_d    = HUNT;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
        LOCKED: begin
          win_word = 1'b1;
          if (limit_hit) begin
            state_d   = HUNT;
            slip_d    = 1'b1;
            win_clear = 1'b1;
          end else begin
            dout_valid_d = 1'b1;
            win_clear    = window_end;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    word_locked_d = (state_d == LOCKED);
    dout_d        = dout_valid_d ? payload : dout_q;
    dout_ctrl_d   = dout_valid_d ? (din[65:64] == HDR_CTRL) : dout_ctrl_q;
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= HUNT;
      good_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      slip_q        <= 1'b0;
      word_locked_q <= 1'b0;
      dout_q        <= '0;
      dout_ctrl_q   <= 1'b0;
      dout_valid_q  <= 1'b0;
      hdr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      slip_q        <= slip_d;
      word_locked_q <= word_locked_d;
      dout_q        <= dout_d;
      dout_ctrl_q   <= dout_ctrl_d;
      dout_valid_q  <= dout_valid_d;
      hdr_err_q     <= hdr_err_d;
    end
  end

  assign slip        = slip_q;
  assign word_locked = word_locked_q;
  assign dout        = dout_q;
  assign dout_ctrl   = dout_ctrl_q;
  assign dout_valid  = dout_valid_q;
  assign hdr_err     = hdr_err_q;

endmodule
`default_nettype wire
